// File: rtl/reg_port_arbiter.sv
`default_nettype none
// ============================================================================
// reg_port_arbiter: round-robin share of one register-access port between two
// pulse/ack requesters. Optional macro REG_ARB_TIMEOUT_EN adds an ack timeout.
// Revision: 1.0
// ============================================================================
module reg_port_arbiter #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic                    req0_wr_en,
    input  logic                    req0_rd_en,
    input  logic [ADDR_WIDTH-1:0]   req0_waddr,
    input  logic [ADDR_WIDTH-1:0]   req0_raddr,
    input  logic [DATA_WIDTH-1:0]   req0_wdata,
    input  logic [DATA_WIDTH/8-1:0] req0_wstrb,
    output logic                    req0_wr_ack,
    output logic                    req0_rd_ack,
    output logic [DATA_WIDTH-1:0]   req0_rdata,
    input  logic                    req1_wr_en,
    input  logic                    req1_rd_en,
    input  logic [ADDR_WIDTH-1:0]   req1_waddr,
    input  logic [ADDR_WIDTH-1:0]   req1_raddr,
    input  logic [DATA_WIDTH-1:0]   req1_wdata,
    input  logic [DATA_WIDTH/8-1:0] req1_wstrb,
    output logic                    req1_wr_ack,
    output logic                    req1_rd_ack,
    output logic [DATA_WIDTH-1:0]   req1_rdata,
    output logic                    m_wr_en,
    output logic                    m_rd_en,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic                    m_wr_ack,
    input  logic                    m_rd_ack,
    output logic                    grant,
    output logic                    timeout_err
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [1:0]            wr_pulse;
    logic [1:0]            rd_pulse;
    logic [1:0]            wr_pend;
    logic [1:0]            rd_pend;
    logic [1:0]            wr_clr;
    logic [1:0]            rd_clr;
    logic [1:0]            cand;
    logic [ADDR_WIDTH-1:0] waddr [2];
    logic [ADDR_WIDTH-1:0] raddr [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [STRB_WIDTH-1:0] wstrb [2];
    logic [DATA_WIDTH-1:0] rdata_q [2];
    logic [1:0]            wr_ack_q;
    logic [1:0]            rd_ack_q;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  owner;
    logic                  op_write;
    logic                  sel_owner;
    logic                  sel_write;
    logic                  any_cand;
    logic                  ack_match;
    logic                  timed_out;

    assign wr_pulse = {req1_wr_en, req0_wr_en};
    assign rd_pulse = {req1_rd_en, req0_rd_en};
    assign waddr[0] = req0_waddr;
    assign waddr[1] = req1_waddr;
    assign raddr[0] = req0_raddr;
    assign raddr[1] = req1_raddr;
    assign wdata[0] = req0_wdata;
    assign wdata[1] = req1_wdata;
    assign wstrb[0] = req0_wstrb;
    assign wstrb[1] = req1_wstrb;

    assign req0_wr_ack = wr_ack_q[0];
    assign req1_wr_ack = wr_ack_q[1];
    assign req0_rd_ack = rd_ack_q[0];
    assign req1_rd_ack = rd_ack_q[1];
    assign req0_rdata  = rdata_q[0];
    assign req1_rdata  = rdata_q[1];

    assign cand      = wr_pend | rd_pend;
    assign any_cand  = |cand;
    assign ack_match = op_write ? m_wr_ack : m_rd_ack;

    // On a tie the requester that did not own the last access wins.
    always_comb begin
        sel_owner = cand[1];
        if (&cand) begin
            sel_owner = ~grant;
        end
        sel_write = wr_pend[sel_owner];
    end

    always_comb begin
        wr_clr = 2'b00;
        rd_clr = 2'b00;
        if (state == RESP) begin
            if (op_write) begin
                wr_clr = owner ? 2'b10 : 2'b01;
            end else begin
                rd_clr = owner ? 2'b10 : 2'b01;
            end
        end
    end

`ifdef REG_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if ((state == WAIT) && !ack_match) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
            if (timed_out) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign timed_out = (state == WAIT) && !ack_match &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;

    assign unused_cfg  = (TIMEOUT_CYCLES != 0);
    assign timed_out   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_cand) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (ack_match || timed_out) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A new pulse wins over the clear issued in the same cycle.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_pend <= 2'b00;
            rd_pend <= 2'b00;
        end else begin
            wr_pend <= wr_pulse | (wr_pend & ~wr_clr);
            rd_pend <= rd_pulse | (rd_pend & ~rd_clr);
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            owner      <= 1'b0;
            op_write   <= 1'b0;
            m_wr_en    <= 1'b0;
            m_rd_en    <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_wstrb    <= '0;
            rsp_data   <= '0;
            wr_ack_q   <= 2'b00;
            rd_ack_q   <= 2'b00;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
            grant      <= 1'b0;
        end else begin
            m_wr_en  <= 1'b0;
            m_rd_en  <= 1'b0;
            wr_ack_q <= 2'b00;
            rd_ack_q <= 2'b00;
            case (state)
                IDLE: begin
                    if (any_cand) begin
                        owner    <= sel_owner;
                        op_write <= sel_write;
                        m_addr   <= sel_write ? waddr[sel_owner] : raddr[sel_owner];
                        m_wdata  <= wdata[sel_owner];
                        m_wstrb  <= wstrb[sel_owner];
                        m_wr_en  <= sel_write;
                        m_rd_en  <= ~sel_write;
                    end
                end
                WAIT: begin
                    if (ack_match) begin
                        rsp_data <= m_rdata;
                    end else if (timed_out) begin
                        rsp_data <= ERR_DATA;
                    end
                end
                RESP: begin
                    wr_ack_q[owner] <= op_write;
                    rd_ack_q[owner] <= ~op_write;
                    if (!op_write) begin
                        rdata_q[owner] <= rsp_data;
                    end
                    grant <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
